// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared constants and helpers for the VGA raster engine.
//   - 640x480@60 default timing constants
//   - calc_total(): sums the four regions of one axis into a total
//   - in_range(): inclusive window test used for the sync/active decode
package vga_timing_pkg;

  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CW       = 10;
  localparam int DEF_COLOR_W  = 8;
  localparam int DEF_PIPE     = 1;

  // Total period of one axis: active, front porch, sync, back porch.
  function automatic int calc_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Inclusive window test, lo <= v <= hi.
  function automatic logic in_range(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_pipe_delay.sv
// vga_pipe_delay
// Parametrised-depth (0..3) shift register with shift enable and
// asynchronous active-low reset to a configurable value. DEPTH=0 is a
// plain wire.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous reset, active-low (loads RST_VAL)
//   en     in   shift enable
//   din    in   W-bit data in
//   dout   out  W-bit data out, DEPTH enabled shifts later
module vga_pipe_delay #(
  parameter int         DEPTH   = 1,
  parameter int         W       = 1,
  parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  if (DEPTH == 0) begin : g_bypass
    assign dout = din;
  end else begin : g_stages
    logic [W-1:0] stage [DEPTH];

    // Shift chain: stage[0] takes din, later stages take their predecessor.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage[i] <= RST_VAL;
        end
      end else if (en) begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) begin
          stage[i] <= stage[i-1];
        end
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Parametrised VGA raster engine: pixel-tick divider, h/v counters,
// sync/blank decode, line/frame markers and a PIPE-stage alignment path
// so colour from an external lookup leaves in step with the syncs.
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous reset, active-low
//   en           in   run enable; low freezes the raster
//   rgb_in       in   colour for the pixel addressed PIPE ticks earlier
//   pix_tick     out  one-clk pixel enable
//   hcount       out  current column (early, lookup address)
//   vcount       out  current row (early)
//   bright       out  early active-video flag
//   line_start   out  one-clk pulse on line wrap
//   frame_start  out  one-clk pulse on frame wrap
//   hsync        out  aligned hsync to pin
//   vsync        out  aligned vsync to pin
//   rgb_out      out  aligned, blanked colour to pin
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = DEF_CW,
  parameter int COLOR_W  = DEF_COLOR_W,
  parameter int PIPE     = DEF_PIPE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [COLOR_W-1:0] rgb_in,
  output logic               pix_tick,
  output logic [CW-1:0]      hcount,
  output logic [CW-1:0]      vcount,
  output logic               bright,
  output logic               line_start,
  output logic               frame_start,
  output logic               hsync,
  output logic               vsync,
  output logic [COLOR_W-1:0] rgb_out
);

  localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if ((H_TOTAL - 1) >= (1 << CW)) begin : g_bad_htotal
    $error("vga_timing_gen: H_TOTAL-1 does not fit in CW bits");
  end
  if ((V_TOTAL - 1) >= (1 << CW)) begin : g_bad_vtotal
    $error("vga_timing_gen: V_TOTAL-1 does not fit in CW bits");
  end
  if ((PIPE < 0) || (PIPE > 3)) begin : g_bad_pipe
    $error("vga_timing_gen: PIPE must be in 0..3");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end

  logic [DW-1:0] divcnt;
  logic          div_last;
  logic          h_wrap;
  logic          v_wrap;
  logic          hs_raw;
  logic          vs_raw;
  logic [2:0]    dly;

  assign div_last = (divcnt == DW'(CLK_DIV - 1));
  // Gated by rst so that with CLK_DIV=1 no tick leaks out while in reset.
  assign pix_tick = en & rst & div_last;

  // Clock divider: counts 0..CLK_DIV-1 while enabled, holds otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      divcnt <= {DW{1'b0}};
    end else if (en) begin
      divcnt <= div_last ? {DW{1'b0}} : divcnt + DW'(1);
    end
  end

  assign h_wrap = (hcount == CW'(H_TOTAL - 1));
  assign v_wrap = (vcount == CW'(V_TOTAL - 1));

  // Raster counters: column advances per tick, row advances on column wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcount <= {CW{1'b0}};
      vcount <= {CW{1'b0}};
    end else if (pix_tick) begin
      if (h_wrap) begin
        hcount <= {CW{1'b0}};
        vcount <= v_wrap ? {CW{1'b0}} : vcount + CW'(1);
      end else begin
        hcount <= hcount + CW'(1);
      end
    end
  end

  assign line_start  = pix_tick & h_wrap;
  assign frame_start = line_start & v_wrap;

  // Raw decode is active-high internally; polarity is applied at the pins.
  assign hs_raw = in_range(int'(hcount), H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC - 1);
  assign vs_raw = in_range(int'(vcount), V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC - 1);
  assign bright = in_range(int'(hcount), 0, H_ACTIVE - 1) &&
                  in_range(int'(vcount), 0, V_ACTIVE - 1);

  // Delays the decode by the colour lookup latency so it meets rgb_in.
  vga_pipe_delay #(
    .DEPTH   (PIPE),
    .W       (3),
    .RST_VAL (3'b000)
  ) u_align (
    .clk   (clk),
    .rst_n (rst),
    .en    (pix_tick),
    .din   ({hs_raw, vs_raw, bright}),
    .dout  (dly)
  );

  // Pin register: applies sync polarity and blanks colour outside active video.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync   <= ~HS_POL;
      vsync   <= ~VS_POL;
      rgb_out <= {COLOR_W{1'b0}};
    end else if (pix_tick) begin
      hsync   <= dly[2] ? HS_POL : ~HS_POL;
      vsync   <= dly[1] ? VS_POL : ~VS_POL;
      rgb_out <= dly[0] ? rgb_in : {COLOR_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Two instances on a shrunken raster (24x11 total): instance 0 with
// CLK_DIV=4, PIPE=1, active-low syncs; instance 1 with CLK_DIV=1, PIPE=2,
// active-high syncs. Both are compared every clock against a reference
// that derives position from the number of pixel ticks since reset.
module tb_vga_timing_gen;

  localparam int HA = 16, HFP = 2, HS = 3, HB = 3;
  localparam int VA = 6,  VFP = 1, VS = 2, VB = 2;
  localparam int HT = HA + HFP + HS + HB;
  localparam int VT = VA + VFP + VS + VB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [7:0] rgb_in = 8'h00;

  logic       pt [2];
  logic [9:0] hc [2];
  logic [9:0] vc [2];
  logic       br [2];
  logic       ls [2];
  logic       fs [2];
  logic       hsy [2];
  logic       vsy [2];
  logic [7:0] rgb [2];

  int n_assert = 0;
  int n_fail   = 0;

  int         md [2];
  int         nt [2];
  logic [7:0] last_rgb [2];

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(4), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(10), .COLOR_W(8), .PIPE(1)
  ) dut0 (
    .clk(clk), .rst(rst), .en(en), .rgb_in(rgb_in),
    .pix_tick(pt[0]), .hcount(hc[0]), .vcount(vc[0]), .bright(br[0]),
    .line_start(ls[0]), .frame_start(fs[0]),
    .hsync(hsy[0]), .vsync(vsy[0]), .rgb_out(rgb[0])
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(10), .COLOR_W(8), .PIPE(2)
  ) dut1 (
    .clk(clk), .rst(rst), .en(en), .rgb_in(rgb_in),
    .pix_tick(pt[1]), .hcount(hc[1]), .vcount(vc[1]), .bright(br[1]),
    .line_start(ls[1]), .frame_start(fs[1]),
    .hsync(hsy[1]), .vsync(vsy[1]), .rgb_out(rgb[1])
  );

  function automatic int cdiv(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic int pipe(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic logic pol(input int d);
    return (d == 0) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic win(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Screen position reached after k ticks since reset.
  function automatic int col(input int k);
    return k % HT;
  endfunction

  function automatic int row(input int k);
    return (k / HT) % VT;
  endfunction

  function automatic logic vis(input int k);
    return (col(k) < HA) && (row(k) < VA);
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s dut%0d: observed %0h expected %0h (ticks %0d)", tag, d, obs, exp, nt[d]);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      md[d] = 0;
      nt[d] = 0;
      last_rgb[d] = 8'h00;
    end
  endtask

  // Combinational outputs for the current input values.
  task automatic check_comb();
    for (int d = 0; d < 2; d++) begin
      logic tick_e, ls_e, fs_e;
      tick_e = rst && en && (md[d] == cdiv(d) - 1);
      ls_e   = tick_e && (col(nt[d]) == HT - 1);
      fs_e   = ls_e && (row(nt[d]) == VT - 1);
      chk("pix_tick", d, 32'(pt[d]), 32'(tick_e));
      chk("line_start", d, 32'(ls[d]), 32'(ls_e));
      chk("frame_start", d, 32'(fs[d]), 32'(fs_e));
    end
  endtask

  // Registered outputs: counters show tick count nt, pins lag by PIPE+1 ticks.
  task automatic check_regs();
    for (int d = 0; d < 2; d++) begin
      logic hs_e, vs_e;
      logic [7:0] rgb_e;
      int p;
      chk("hcount", d, 32'(hc[d]), 32'(col(nt[d])));
      chk("vcount", d, 32'(vc[d]), 32'(row(nt[d])));
      chk("bright", d, 32'(br[d]), 32'(vis(nt[d])));
      if (nt[d] < pipe(d) + 1) begin
        hs_e  = ~pol(d);
        vs_e  = ~pol(d);
        rgb_e = 8'h00;
      end else begin
        p     = nt[d] - pipe(d) - 1;
        hs_e  = win(col(p), HA + HFP, HA + HFP + HS - 1) ? pol(d) : ~pol(d);
        vs_e  = win(row(p), VA + VFP, VA + VFP + VS - 1) ? pol(d) : ~pol(d);
        rgb_e = vis(p) ? last_rgb[d] : 8'h00;
      end
      chk("hsync", d, 32'(hsy[d]), 32'(hs_e));
      chk("vsync", d, 32'(vsy[d]), 32'(vs_e));
      chk("rgb_out", d, 32'(rgb[d]), 32'(rgb_e));
    end
  endtask

  // One clock: drive inputs at the falling edge, check, clock, check again.
  task automatic cyc(input logic rst_v, input logic en_v, input logic [7:0] rgb_v);
    @(negedge clk);
    rst = rst_v;
    en = en_v;
    rgb_in = rgb_v;
    #1;
    if (!rst) model_reset();
    check_comb();
    @(posedge clk);
    if (rst && en) begin
      for (int d = 0; d < 2; d++) begin
        if (md[d] == cdiv(d) - 1) begin
          md[d] = 0;
          nt[d]++;
          last_rgb[d] = rgb_in;
        end else begin
          md[d]++;
        end
      end
    end
    #1;
    check_regs();
  endtask

  function automatic logic rnd_en(input int one_in);
    return ($urandom_range(one_in - 1) != 0);
  endfunction

  initial begin
    int guard;
    model_reset();

    // Reset held with random colour and enable.
    for (int i = 0; i < 4; i++) cyc(1'b0, rnd_en(2), 8'($urandom));
    chk("reset_hsync_lvl", 0, 32'(hsy[0]), 32'd1);
    chk("reset_vsync_lvl", 1, 32'(vsy[1]), 32'd0);

    // Free run, beyond one full frame of the divided instance.
    for (int i = 0; i < 1200; i++) cyc(1'b1, 1'b1, 8'($urandom));

    // Freeze mid-line for 50 clocks, then resume.
    guard = 0;
    while ((col(nt[0]) != 10 || md[0] != 0) && guard < 400) begin
      cyc(1'b1, 1'b1, 8'($urandom));
      guard++;
    end
    chk("reach_col10", 0, 32'(col(nt[0])), 32'd10);
    for (int i = 0; i < 50; i++) cyc(1'b1, 1'b0, 8'($urandom));
    chk("frozen_col", 0, 32'(hc[0]), 32'd10);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 8'($urandom));
    chk("resume_col", 0, 32'(hc[0]), 32'd11);
    for (int i = 0; i < 300; i++) cyc(1'b1, 1'b1, 8'($urandom));

    // Constant white with sporadic enable drops.
    for (int i = 0; i < 700; i++) cyc(1'b1, rnd_en(8), 8'hFF);

    // Asynchronous reset between clock edges mid-frame.
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_regs();
    check_comb();
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 8'($urandom));
    for (int i = 0; i < 600; i++) cyc(1'b1, rnd_en(16), 8'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
